// File: rtl/imem_loader.sv
// Byte-stream loader that fills the instruction memory from a framed image.
// Frame: 16-bit big-endian length, payload, and one checksum byte. The CPU is held while the image loads.
module imem_loader #(
    parameter  int MEM_CELL_SIZE  = 8,
    parameter  int INSTR_MEM_SIZE = 256,
    localparam int ADDR_WIDTH     = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [MEM_CELL_SIZE-1:0] in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output logic [ADDR_WIDTH:0]      bytes_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0]         MAX_LEN = 16'(INSTR_MEM_SIZE);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                     r_state;
    logic [15:0]                r_len;
    logic [ADDR_WIDTH:0]        r_count;
    logic [MEM_CELL_SIZE-1:0]   r_sum;
    logic                       r_mem_we;
    logic [ADDR_WIDTH-1:0]      r_mem_addr;
    logic [MEM_CELL_SIZE-1:0]   r_mem_wdata;
    logic                       r_cpu_hold;
    logic                       r_done;
    logic                       r_error;

    logic                       w_ready;
    logic                       w_accept;
    logic [15:0]                w_len;
    logic                       w_len_bad;
    logic [ADDR_WIDTH:0]        w_count_next;
    logic [MEM_CELL_SIZE-1:0]   w_sum_next;

    assign w_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_accept = w_ready && in_valid;

    // Length is judged as the low byte arrives, so a bad length never reaches DATA.
    assign w_len        = {r_len[15:8], in_data[7:0]};
    assign w_len_bad    = (w_len == 16'd0) || (w_len > MAX_LEN) || (w_len[1:0] != 2'b00);
    assign w_count_next = r_count + CNT_ONE;
    assign w_sum_next   = r_sum + in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // NOTE: defaulting the strobe low here makes every write a one-cycle pulse.
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_LEN_HI;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_count    <= '0;
                        r_sum      <= '0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_data[7:0];
                        r_state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_count[ADDR_WIDTH-1:0];
                        r_mem_wdata <= in_data;
                        r_count     <= w_count_next;
                        r_sum       <= w_sum_next;
                        if (16'(w_count_next) == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (w_sum_next == '0) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = w_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign bytes_loaded = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level model predicts writes and final status,
// and a per-cycle monitor compares every write strobe against that prediction.
module tb_imem_loader;

    localparam int AW = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   bytes_loaded;

    imem_loader #(.MEM_CELL_SIZE(8), .INSTR_MEM_SIZE(256)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  model_written = 0;
    wr_t exp_q[$];
    int  log_addr[$];
    int  log_data[$];
    int  wr_cycle[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_we === 1'b1) begin
                wr_t e;
                log_addr.push_back(int'(mem_addr));
                log_data.push_back(int'(mem_wdata));
                wr_cycle.push_back(cyc);
                model_written++;
                check("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e.addr));
                    check("write_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            check("bytes_loaded_track", 32'(bytes_loaded), 32'(model_written));
        end
    end

    task automatic do_start();
        log_addr.delete();
        log_data.delete();
        wr_cycle.delete();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        in_valid      = 1'b0;
        model_written = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps) begin
            int n = int'($urandom_range(0, 2));
            in_valid = 1'b0;
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        check("byte_handshake", 32'(ok), 32'd1);
    endtask

    task automatic push_exp(input int addr, input int data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input bq_t fr, input bit gaps);
        int  n     = int'({fr[0], fr[1]});
        bit  len_ok = (n != 0) && (n <= 256) && (n % 4 == 0);
        int  sum   = 0;
        bit  good  = 1'b0;
        int  nsend = 2;
        if (len_ok) begin
            for (int k = 0; k < n; k++) begin
                push_exp(k, int'(fr[2 + k]));
                sum += int'(fr[2 + k]);
            end
            good  = ((sum + int'(fr[2 + n])) % 256) == 0;
            nsend = n + 3;
        end
        do_start();
        check("ready_after_start", 32'(in_ready), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        check("error_cleared", 32'(error), 32'd0);
        check("hold_on_start", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < nsend; i++) send_byte(fr[i], gaps);
        in_valid = 1'b0;
        check("ready_low_after_frame", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("final_done", 32'(done), 32'(good));
        check("final_error", 32'(error), 32'(!good));
        check("final_cpu_hold", 32'(cpu_hold), 32'(!good));
        check("final_bytes_loaded", 32'(bytes_loaded), 32'(len_ok ? n : 0));
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic bq_t q7(input logic [7:0] a [7]);
        bq_t q;
        foreach (a[i]) q.push_back(a[i]);
        return q;
    endfunction

    function automatic bq_t q2(input logic [7:0] hi, input logic [7:0] lo);
        bq_t q;
        q.push_back(hi);
        q.push_back(lo);
        return q;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] good_fr [7];
        logic [7:0] bad_fr  [7];
        bq_t        full_fr;

        good_fr = '{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
        bad_fr  = '{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD4};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_bytes_loaded", 32'(bytes_loaded), 32'd0);
        rst = 1'b0;

        // Good load, back-to-back.
        run_frame(q7(good_fr), 1'b0);
        check("lit_good_nwrites", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            check("lit_good_w0_addr", 32'(log_addr[0]), 32'd0);
            check("lit_good_w0_data", 32'(log_data[0]), 32'h20);
            check("lit_good_w3_addr", 32'(log_addr[3]), 32'd3);
            check("lit_good_w3_data", 32'(log_data[3]), 32'h05);
            check("lit_good_consecutive", 32'(wr_cycle[3] - wr_cycle[0]), 32'd3);
        end
        check("lit_good_done", 32'(done), 32'd1);
        check("lit_good_count", 32'(bytes_loaded), 32'd4);

        // Bad checksum: writes still land, error raised, CPU stays held.
        run_frame(q7(bad_fr), 1'b0);
        check("lit_badcs_nwrites", 32'(log_addr.size()), 32'd4);
        check("lit_badcs_error", 32'(error), 32'd1);
        check("lit_badcs_hold", 32'(cpu_hold), 32'd1);

        // Bad lengths: not a multiple of 4, too large, zero.
        run_frame(q2(8'h00, 8'h06), 1'b0);
        check("lit_len6_nwrites", 32'(log_addr.size()), 32'd0);
        check("lit_len6_error", 32'(error), 32'd1);
        run_frame(q2(8'h01, 8'h04), 1'b0);
        check("lit_len260_error", 32'(error), 32'd1);
        run_frame(q2(8'h00, 8'h00), 1'b0);
        check("lit_len0_error", 32'(error), 32'd1);

        // Full memory with random in_valid gaps; checksum of 0..255 is 0x80.
        full_fr.push_back(8'h01);
        full_fr.push_back(8'h00);
        for (int i = 0; i < 256; i++) full_fr.push_back(8'(i));
        full_fr.push_back(8'h80);
        run_frame(full_fr, 1'b1);
        check("lit_full_count", 32'(bytes_loaded), 32'd256);
        check("lit_full_done", 32'(done), 32'd1);
        check("lit_full_nwrites", 32'(log_addr.size()), 32'd256);
        if (log_addr.size() == 256) begin
            check("lit_full_last_addr", 32'(log_addr[255]), 32'd255);
            check("lit_full_mid_data", 32'(log_data[128]), 32'd128);
        end

        // Asynchronous reset after two payload bytes.
        push_exp(0, 8'h20);
        push_exp(1, 8'h08);
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check("arst_bytes_loaded", 32'(bytes_loaded), 32'd0);
        exp_q.delete();
        model_written = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'(in_ready), 32'd0);
        run_frame(q7(good_fr), 1'b0);
        check("lit_reload_done", 32'(done), 32'd1);

        // start during DATA is ignored.
        for (int i = 0; i < 4; i++) push_exp(i, int'(good_fr[2 + i]));
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_data_ignored", 32'(in_ready), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hD3, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midstart_done", 32'(done), 32'd1);
        check("midstart_count", 32'(bytes_loaded), 32'd4);
        check("midstart_writes_seen", 32'(exp_q.size()), 32'd0);

        // Restart from ERR into a good load.
        run_frame(q2(8'h00, 8'h06), 1'b0);
        run_frame(q7(good_fr), 1'b0);
        check("lit_restart_done", 32'(done), 32'd1);
        check("lit_restart_error", 32'(error), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that writes a program image into the byte-wide instruction memory of the MIPS processor, filling the cells that the fetch path later reads big-endian, four bytes per instruction. It receives a length-prefixed, checksummed frame over a valid/ready byte interface and drives a registered single-byte write port. It holds the CPU while loading and reports completion or error.

## Interface
- MEM_CELL_SIZE, 8, width of one memory cell and of the input byte
- INSTR_MEM_SIZE, 256, number of memory cells; ADDR_WIDTH = $clog2(INSTR_MEM_SIZE)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse, begins a load (honoured in IDLE, DONE, ERR only)
- in_valid  input  1  in_data holds a valid byte
- in_data  input  MEM_CELL_SIZE  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  write strobe to instruction memory
- mem_addr  output  ADDR_WIDTH  byte address of the write
- mem_wdata  output  MEM_CELL_SIZE  byte to write
- cpu_hold  output  1  processor held in reset/stall
- done  output  1  last load completed with good checksum (level)
- error  output  1  last load failed (level)
- bytes_loaded  output  ADDR_WIDTH+1  payload bytes written in current/last load

## Operation
- Frame: LEN_HI, LEN_LO (16-bit big-endian byte count N), N payload bytes, 1 checksum byte.
- Byte accepted when in_valid && in_ready on a rising edge.
- States: IDLE -> (start) LEN_HI -> LEN_LO -> DATA -> CSUM -> DONE | ERR; DONE/ERR -> (start) LEN_HI.
- in_ready = 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in IDLE, DONE, ERR.
- Length check at LEN_LO acceptance: N == 0, N > INSTR_MEM_SIZE, or N[1:0] != 0 -> ERR; no payload written.
- DATA: k-th accepted payload byte (k from 0) written to address k; after N-th byte go to CSUM. Address never wraps (N <= INSTR_MEM_SIZE guaranteed by length check).
- Checksum: 8-bit running sum of payload bytes; (sum + checksum byte) mod 256 == 0 -> DONE, else ERR. Already-written bytes are not rolled back on ERR.
- start: on entry to LEN_HI clear done, error, bytes_loaded, running sum; set cpu_hold. start in LEN_HI..CSUM ignored.
- cpu_hold: set on start, cleared on entering DONE, remains 1 in ERR until rst.
- Width rules: N held in 16-bit register; payload count ADDR_WIDTH+1 bits so N = INSTR_MEM_SIZE is representable.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, done 0, error 0, bytes_loaded 0.
- Write latency 1: payload byte accepted at edge t -> mem_we=1 with mem_addr/mem_wdata valid during cycle t..t+1, written by memory at edge t+1. mem_we is a single-cycle pulse per byte; back-to-back bytes give consecutive pulses.
- bytes_loaded increments at the same edge mem_we rises.
- DONE/ERR and done/error asserted at the edge accepting the checksum byte (or LEN_LO for length errors); in_ready is 0 the following cycle.
- in_valid gaps: state held, no write, no timeout.
- rst mid-load: all outputs immediately return to reset values asynchronously; partial memory contents undefined to the CPU, loader restarts only on next start.
- start and in_valid in the same cycle while in IDLE: byte is not accepted (in_ready 0 in IDLE).

## Test plan
- Good load: start; bytes 00 04 20 08 00 05 D3 back-to-back -> writes (0,20),(1,08),(2,00),(3,05) on four consecutive cycles; done=1, error=0, cpu_hold=0, bytes_loaded=4.
- Bad checksum: same frame with D4 -> four writes occur, error=1, done=0, cpu_hold stays 1.
- Bad length: 00 06 -> error=1 after second byte, mem_we never asserted, in_ready 0; also 01 04 (260 > 256) and 00 00 -> error.
- Full memory + backpressure: N=0x0100, 256 bytes i&0xFF with in_valid toggled randomly -> addresses 0..255 each written exactly once in order, bytes_loaded=256, done=1 with correct checksum 0x80.
- Reset mid-DATA: assert rst after 2 payload bytes -> all outputs at reset values asynchronously, state IDLE; subsequent good load completes with done=1.
- Restart: start in DATA ignored; start after ERR clears error and accepts a new good frame to done=1.
